apb_mac_master: RTL

APB requester that drives the MAC peripheral from the system side. It accepts a multiply command on a simple start/done interface and writes the packed operands to the peripheral's operand register. It then waits for the MAC completion sideband, reads the result register back, and returns the product with an error code. It sits between a local controller (test sequencer or CPU glue) and the APB port of the MAC peripheral.

---
 rtl/apb_mac_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_mac_master.sv
// APB requester for the MAC peripheral: writes packed operands, waits for the
// MAC completion sideband, reads the product back and reports an error code.
module apb_mac_master #(
    parameter int unsigned OPERAND_WIDTH = 8,
    parameter logic [31:0] OPND_ADDR     = 32'h0000_0000,
    parameter logic [31:0] RSLT_ADDR     = 32'h0000_0004,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       start,
    input  logic [OPERAND_WIDTH-1:0]   op_a,
    input  logic [OPERAND_WIDTH-1:0]   op_b,
    input  logic                       mac_ready,
    input  logic                       PREADY,
    input  logic [31:0]                PRDATA,
    input  logic                       PSLVERR,
    output logic [31:0]                PADDR,
    output logic                       PSELx,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [31:0]                PWDATA,
    output logic                       busy,
    output logic                       done,
    output logic [2*OPERAND_WIDTH-1:0] result,
    output logic [1:0]                 err
);

    localparam int unsigned PW = 2 * OPERAND_WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrWrite   = 2'b01;
    localparam logic [1:0] ErrRead    = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrAccess,
        StWaitMac,
        StRdSetup,
        StRdAccess,
        StDone
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          mac_seen_q;
    logic          expired;

    // Only the low product bits of the result register are meaningful.
    logic unused_prdata;
    assign unused_prdata = ^PRDATA[31:PW];

    // Wait budget exhausted in the current wait state.
    assign expired = (cnt_q == CntLast);

    // Request FSM with all APB and status outputs registered.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mac_seen_q <= 1'b0;
            PADDR      <= '0;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            err        <= ErrOk;
        end else begin
            done <= 1'b0;
            // Completion may arrive before we start waiting for it.
            if (mac_ready && state_q != StIdle) begin
                mac_seen_q <= 1'b1;
            end
            if (state_q inside {StWrAccess, StWaitMac, StRdAccess}) begin
                cnt_q <= cnt_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mac_seen_q <= 1'b0;
                        result     <= '0;
                        err        <= ErrOk;
                        // Operands are captured straight into the write data register.
                        PWDATA     <= 32'({op_a, op_b});
                        PADDR      <= OPND_ADDR;
                        PWRITE     <= 1'b1;
                        PSELx      <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= StWrSetup;
                    end
                end
                StWrSetup: begin
                    PENABLE <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= StWrAccess;
                end
                StWrAccess: begin
                    if (PREADY) begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            err     <= ErrWrite;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StWaitMac;
                        end
                    end else if (expired) begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        err     <= ErrTimeout;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StWaitMac: begin
                    if (mac_seen_q || mac_ready) begin
                        PSELx   <= 1'b1;
                        PWRITE  <= 1'b0;
                        PADDR   <= RSLT_ADDR;
                        state_q <= StRdSetup;
                    end else if (expired) begin
                        err     <= ErrTimeout;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StRdSetup: begin
                    PENABLE <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= StRdAccess;
                end
                StRdAccess: begin
                    if (PREADY || expired) begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                        if (!PREADY) begin
                            err <= ErrTimeout;
                        end else if (PSLVERR) begin
                            err <= ErrRead;
                        end else begin
                            result <= PRDATA[PW-1:0];
                            err    <= ErrOk;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
